latch_input_debouncer: RTL and testbench
========================================

// Module: latch_input_debouncer
// PURPOSE
//  Input-conditioning stage that sits directly upstream of the latch
//  experiments (a/b set/reset inputs).
//  - Synchronises two raw, asynchronous, bouncy inputs (switches/buttons).
//  - Debounces each input and produces clean levels plus one-cycle edge
//    pulses for the latch stage.
//  - Flags the forbidden "both asserted" input combination.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable synchronised samples needed to commit a change (>=2)
//  CNT_W            5   counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk        input   1  single clock, rising-edge
//  rst        input   1  synchronous reset, active-high
//  a_raw      input   1  raw asynchronous input A (set side)
//  b_raw      input   1  raw asynchronous input B (reset side)
//  a_clean    output  1  debounced level of A
//  b_clean    output  1  debounced level of B
//  a_rise     output  1  1-cycle pulse when a_clean goes 0->1
//  a_fall     output  1  1-cycle pulse when a_clean goes 1->0
//  b_rise     output  1  1-cycle pulse when b_clean goes 0->1
//  b_fall     output  1  1-cycle pulse when b_clean goes 1->0
//  conflict   output  1  a_clean & b_clean (forbidden S=R=1 condition)
//  busy       output  1  either channel is in a WAIT state
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst is synchronous and active-high.
//  - Reset: sync flops, counters, clean outputs, pulses, conflict and busy
//    all go to 0. Both FSMs enter ST_LOW. Reset overrides all other activity.
//  - Synchroniser: each channel has 2 flops, raw -> s1 -> s2.
//    The FSM uses s2 only.
//  - FSM per channel, states ST_LOW, WAIT_HI, ST_HI, WAIT_LO:
//    ST_LOW : s2=1 -> WAIT_HI, cnt<=1; otherwise stay, cnt<=0.
//    WAIT_HI: s2=0 -> ST_LOW, cnt<=0 (bounce rejected, no pulse).
//             s2=1, cnt==DEBOUNCE_CYCLES-1 -> ST_HI, clean<=1, rise<=1.
//             s2=1 otherwise -> cnt<=cnt+1.
//    ST_HI and WAIT_LO mirror ST_LOW and WAIT_HI with polarity swapped;
//    the commit sets clean<=0 and fall<=1.
//  - Latency: call the first edge that samples the new raw value edge 1.
//    clean changes and the pulse asserts at edge DEBOUNCE_CYCLES+2,
//    provided raw stays stable throughout.
//  - Pulses are registered, exactly 1 cycle wide, and asserted in the same
//    cycle clean changes. rise and fall are never both high.
//  - Wrap-around: the counter never exceeds DEBOUNCE_CYCLES-1. It clears on
//    every commit and every bounce reject.
//  - Channels are fully independent. Simultaneous commits on A and B are
//    both reported in the same cycle.
//  - conflict and busy are combinational from registered state; no extra
//    latency.
//  - Reset mid-WAIT: the pending change is discarded, no pulse is issued.
//    If raw is still asserted when rst drops, a full debounce restarts.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. rst 2 cycles, a_raw=b_raw=0, 20 cycles
//     -> all outputs 0; both FSMs stay in ST_LOW.
//  2. a_raw 0->1 and held
//     -> a_clean=1 and a_rise=1 at edge 6 only; a_rise=0 at edge 7;
//        busy=1 from edge 3 to edge 5.
//  3. a_raw high 3 cycles, low 1 cycle, then held high
//     -> first attempt rejected (no pulse); exactly one a_rise,
//        6 edges after the final 0->1 transition.
//  4. a held high, then b_raw 0->1
//     -> b_rise and conflict=1 at b's edge 6; then b_raw->0
//     -> b_fall and conflict=0 after 6 edges.
//  5. a_clean=1 steady, a_raw drops for 1 cycle
//     -> no a_fall; a_clean remains 1.
//  6. a_raw=1, rst pulsed while FSM is in WAIT_HI
//     -> a_clean stays 0 with no pulse; a_rise appears 6 edges after
//        rst deasserts (re-synchronisation included).

Source files
------------

// File: rtl/latch_input_debouncer.sv
// Input conditioning for the latch experiments. Two raw, bouncy inputs (A = set side,
// B = reset side) each pass through a two-flop synchroniser and a debounce FSM. The
// block produces clean levels, one-cycle edge pulses, a forbidden-combination flag
// (both clean levels high) and a busy flag.
module latch_input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_clean,
    output logic b_clean,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic conflict,
    output logic busy
);

    localparam int unsigned      N_CH     = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    // Channel 0 is A, channel 1 is B
    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  s1_q;
    logic [N_CH-1:0]  s2_q;
    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  clean_q;
    logic [N_CH-1:0]  clean_d;
    logic [N_CH-1:0]  rise_q;
    logic [N_CH-1:0]  rise_d;
    logic [N_CH-1:0]  fall_q;
    logic [N_CH-1:0]  fall_d;
    logic             busy_c;

    assign raw = {b_raw, a_raw};

    // Two-flop synchroniser per channel; the FSMs look only at s2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // FSM state, stability counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= '0;
            end
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Debounce next-state: a change commits only after DEBOUNCE_CYCLES agreeing samples
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_LOW: begin
                    if (s2_q[i]) begin
                        state_d[i] = WAIT_HI;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                WAIT_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_HI;
                        cnt_d[i]   = '0;
                        clean_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = WAIT_LO;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                WAIT_LO: begin
                    if (s2_q[i]) begin
                        state_d[i] = ST_HI;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                        clean_d[i] = 1'b0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Busy whenever either channel is qualifying a pending change
    always_comb begin
        busy_c = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (state_q[i] == WAIT_HI || state_q[i] == WAIT_LO) begin
                busy_c = 1'b1;
            end
        end
    end

    assign a_clean  = clean_q[0];
    assign b_clean  = clean_q[1];
    assign a_rise   = rise_q[0];
    assign a_fall   = fall_q[0];
    assign b_rise   = rise_q[1];
    assign b_fall   = fall_q[1];
    assign conflict = clean_q[0] & clean_q[1];
    assign busy     = busy_c;

endmodule

// File: tb/tb_latch_input_debouncer.sv
// Directed bench for latch_input_debouncer with DEBOUNCE_CYCLES=4.
// "Edge k" is the k-th rising edge after an input change; outputs are sampled 1ns after it.
module tb_latch_input_debouncer;

    localparam int unsigned DC = 4;

    logic clk;
    logic rst;
    logic a_raw;
    logic b_raw;
    logic a_clean;
    logic b_clean;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic conflict;
    logic busy;

    int vec_cnt;
    int err_cnt;
    int rise_seen;

    latch_input_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a_clean (a_clean),
        .b_clean (b_clean),
        .a_rise  (a_rise),
        .a_fall  (a_fall),
        .b_rise  (b_rise),
        .b_fall  (b_fall),
        .conflict(conflict),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [7:0] outs();
        return {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, conflict, busy};
    endfunction

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst   = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;

        // 1. Reset, then idle inputs: everything stays 0
        steps(2);
        chk("t1_reset_outs", 32'(outs()), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k % 5 == 0) chk($sformatf("t1_idle_e%0d", k), 32'(outs()), 32'h0);
        end

        // 2. Clean A press: commit at edge 6, busy on edges 3..5
        a_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t2_aclean_e%0d", k), 32'(a_clean), 32'(k >= 6));
            chk($sformatf("t2_arise_e%0d", k), 32'(a_rise), 32'(k == 6));
            chk($sformatf("t2_busy_e%0d", k), 32'(busy), 32'(k >= 3 && k <= 5));
        end

        // Release A: fall pulse at edge 6
        a_raw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t2r_afall_e%0d", k), 32'(a_fall), 32'(k == 6));
            chk($sformatf("t2r_aclean_e%0d", k), 32'(a_clean), 32'(k < 6));
        end

        // 3. Bounce: high 3, low 1, then held high; final 0->1 is sampled at edge 5
        rise_seen = 0;
        a_raw = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 3) a_raw = 1'b0;
            if (k == 4) a_raw = 1'b1;
            if (a_rise) rise_seen++;
            chk($sformatf("t3_arise_e%0d", k), 32'(a_rise), 32'(k == 10));
            chk($sformatf("t3_aclean_e%0d", k), 32'(a_clean), 32'(k >= 10));
        end
        chk("t3_rise_count", 32'(rise_seen), 32'd1);

        // 4. A held high, B press then release: conflict follows B's clean level
        b_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t4_brise_e%0d", k), 32'(b_rise), 32'(k == 6));
            chk($sformatf("t4_conf_e%0d", k), 32'(conflict), 32'(k >= 6));
        end
        b_raw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t4_bfall_e%0d", k), 32'(b_fall), 32'(k == 6));
            chk($sformatf("t4_conf2_e%0d", k), 32'(conflict), 32'(k < 6));
            chk($sformatf("t4_aclean_e%0d", k), 32'(a_clean), 32'd1);
        end

        // 5. One-cycle dropout on a steady high A is rejected
        a_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) a_raw = 1'b1;
            chk($sformatf("t5_afall_e%0d", k), 32'(a_fall), 32'd0);
            chk($sformatf("t5_aclean_e%0d", k), 32'(a_clean), 32'd1);
        end

        // 6. Reset during WAIT_HI discards the pending rise; full debounce restarts after
        a_raw = 1'b0;
        steps(8);
        chk("t6_pre_aclean", 32'(a_clean), 32'd0);
        a_raw = 1'b1;
        steps(4);
        chk("t6_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("t6_rst_outs", 32'(outs()), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t6_arise_e%0d", k), 32'(a_rise), 32'(k == 6));
            chk($sformatf("t6_aclean_e%0d", k), 32'(a_clean), 32'(k >= 6));
        end

        // 7. Simultaneous A and B press: both pulses and conflict on the same edge
        a_raw = 1'b0;
        steps(8);
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t7_outs_e%0d", k), 32'(outs()),
                (k == 6) ? 32'hEA : (k == 7) ? 32'hC2 : (k >= 3) ? 32'h01 : 32'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
